// File: rtl/melody_if.sv
// Control and note bus between the playback controller and melody_sequencer.
interface melody_if;
  logic       start;
  logic       stop;
  logic       loop_en;
  logic [2:0] note_bin;
  logic       note_valid;
  logic       busy;
  logic       done;
  logic [3:0] step_idx;

  modport master (
    output start, stop, loop_en,
    input  note_bin, note_valid, busy, done, step_idx
  );

  modport slave (
    input  start, stop, loop_en,
    output note_bin, note_valid, busy, done, step_idx
  );
endinterface

// File: rtl/melody_sequencer.sv
// Steps through a fixed 16-entry song ROM, driving note_bin/note_valid into the dds
// tone generator with per-note beat durations, optional silent gaps, and start/stop/loop control.
module melody_sequencer #(
  parameter int unsigned BEAT_CYCLES = 250000,
  parameter int unsigned GAP_CYCLES  = 20000,
  parameter int unsigned SONG_LEN    = 16
) (
  input  logic     clk,
  input  logic     rst,
  melody_if.slave  bus
);

  localparam int unsigned CNT_W  = 32;
  localparam int unsigned STEP_W = 4;
  localparam int unsigned NOTE_W = 3;
  localparam int unsigned DUR_W  = 3;

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SONG_LEN - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES) - CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
  } rom_entry_t;

  // Song ROM: rising scale of single beats, then falling scale of double beats.
  function automatic rom_entry_t rom_lookup(input logic [STEP_W-1:0] idx);
    rom_entry_t e;
    if (!idx[3]) begin
      e.note = idx[NOTE_W-1:0];
      e.dur  = DUR_W'(0);
    end else begin
      e.note = ~idx[NOTE_W-1:0];
      e.dur  = DUR_W'(1);
    end
    return e;
  endfunction

  // Down-counter load value: the note lasts (dur+1)*BEAT_CYCLES cycles, counted to zero.
  function automatic logic [CNT_W-1:0] play_load(input logic [DUR_W-1:0] dur);
    return (CNT_W'(dur) + CNT_W'(1)) * CNT_W'(BEAT_CYCLES) - CNT_W'(1);
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic              note_valid_q, busy_q, done_q;

  logic              advance;
  logic [STEP_W-1:0] nxt_step;
  rom_entry_t        nxt_entry;
  rom_entry_t        first_entry;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    step_d      = step_q;
    note_d      = note_q;
    advance     = 1'b0;
    nxt_step    = step_q + STEP_W'(1);
    nxt_entry   = rom_lookup(nxt_step);
    first_entry = rom_lookup(STEP_W'(0));

    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          state_d = PLAY;
          step_d  = STEP_W'(0);
          note_d  = first_entry.note;
          cnt_d   = play_load(first_entry.dur);
        end
      end
      PLAY: begin
        if (cnt_q == CNT_W'(0)) begin
          if (GAP_CYCLES != 0) begin
            state_d = GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            advance = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(0)) begin
          advance = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // End of a step: next entry, wrap on loop, or finish the song.
    if (advance) begin
      if (step_q != LAST_STEP) begin
        state_d = PLAY;
        step_d  = nxt_step;
        note_d  = nxt_entry.note;
        cnt_d   = play_load(nxt_entry.dur);
      end else if (bus.loop_en) begin
        state_d = PLAY;
        step_d  = STEP_W'(0);
        note_d  = first_entry.note;
        cnt_d   = play_load(first_entry.dur);
      end else begin
        state_d = DONE;
        step_d  = STEP_W'(0);
        note_d  = NOTE_W'(0);
        cnt_d   = CNT_W'(0);
      end
    end

    // Stop overrides everything outside IDLE and suppresses the done pulse.
    if (bus.stop && state_q != IDLE) begin
      state_d = IDLE;
      step_d  = STEP_W'(0);
      note_d  = NOTE_W'(0);
      cnt_d   = CNT_W'(0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= CNT_W'(0);
      step_q       <= STEP_W'(0);
      note_q       <= NOTE_W'(0);
      note_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      step_q       <= step_d;
      note_q       <= note_d;
      note_valid_q <= (state_d == PLAY);
      busy_q       <= (state_d == PLAY) || (state_d == GAP);
      done_q       <= (state_d == DONE);
    end
  end

  assign bus.note_bin   = note_q;
  assign bus.note_valid = note_valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.step_idx   = step_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: three parameterisations driven by shared stimulus and
// compared cycle by cycle against a timeline model of the song.
module tb_melody_sequencer;

  localparam int unsigned P_B[3] = '{4, 4, 3};
  localparam int unsigned P_G[3] = '{2, 0, 1};
  localparam int unsigned P_L[3] = '{16, 16, 5};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic loop_en = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  int done_seen_a = 0;
  string names[3] = '{"A", "B", "C"};

  always #5 clk = ~clk;

  melody_if if_a ();
  melody_if if_b ();
  melody_if if_c ();

  assign if_a.start = start;
  assign if_a.stop = stop;
  assign if_a.loop_en = loop_en;
  assign if_b.start = start;
  assign if_b.stop = stop;
  assign if_b.loop_en = loop_en;
  assign if_c.start = start;
  assign if_c.stop = stop;
  assign if_c.loop_en = loop_en;

  melody_sequencer #(.BEAT_CYCLES(4), .GAP_CYCLES(2), .SONG_LEN(16)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a.slave));
  melody_sequencer #(.BEAT_CYCLES(4), .GAP_CYCLES(0), .SONG_LEN(16)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b.slave));
  melody_sequencer #(.BEAT_CYCLES(3), .GAP_CYCLES(1), .SONG_LEN(5)) dut_c (
    .clk(clk), .rst(rst), .bus(if_c.slave));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Song timeline: each step is (dur+1)*B audible cycles followed by G silent ones.
  function automatic int unsigned song_period(int k);
    int unsigned sum = 0;
    for (int st = 0; st < int'(P_L[k]); st++)
      sum += ((st < 8) ? 1 : 2) * P_B[k] + P_G[k];
    return sum;
  endfunction

  // {step[3:0], note[2:0], audible} for elapsed cycle e since the song started.
  function automatic logic [7:0] model_pos(int k, int unsigned e);
    int unsigned rem = e;
    for (int st = 0; st < int'(P_L[k]); st++) begin
      int unsigned note;
      int unsigned len;
      note = (st < 8) ? st : 15 - st;
      len  = ((st < 8) ? 1 : 2) * P_B[k];
      if (rem < len) return {4'(st), 3'(note), 1'b1};
      rem -= len;
      if (rem < P_G[k]) return {4'(st), 3'(note), 1'b0};
      rem -= P_G[k];
    end
    return 8'hFF;
  endfunction

  function automatic logic [9:0] obs(int k);
    case (k)
      0: return {if_a.step_idx, if_a.note_bin, if_a.note_valid, if_a.busy, if_a.done};
      1: return {if_b.step_idx, if_b.note_bin, if_b.note_valid, if_b.busy, if_b.done};
      default: return {if_c.step_idx, if_c.note_bin, if_c.note_valid, if_c.busy, if_c.done};
    endcase
  endfunction

  bit m_act[3];
  bit m_done[3];
  int unsigned m_e[3];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        m_act[k]  <= 1'b0;
        m_done[k] <= 1'b0;
        m_e[k]    <= 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (m_done[k]) begin
          m_done[k] <= 1'b0;
        end else if (!m_act[k]) begin
          if (start && !stop) begin
            m_act[k] <= 1'b1;
            m_e[k]   <= 0;
          end
        end else if (stop) begin
          m_act[k] <= 1'b0;
        end else if (m_e[k] == song_period(k) - 1) begin
          if (loop_en) begin
            m_e[k] <= 0;
          end else begin
            m_act[k]  <= 1'b0;
            m_done[k] <= 1'b1;
          end
        end else begin
          m_e[k] <= m_e[k] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (if_a.done) done_seen_a++;
    for (int k = 0; k < 3; k++) begin
      logic [9:0] g;
      logic [9:0] x;
      logic [7:0] pos;
      g = obs(k);
      if (m_done[k]) begin
        x = 10'b0000_000_001;
      end else if (m_act[k]) begin
        pos = model_pos(k, m_e[k]);
        x = {pos, 1'b1, 1'b0};
      end else begin
        x = 10'd0;
      end
      check({names[k], ".step_idx"}, 32'(g[9:6]), 32'(x[9:6]));
      check({names[k], ".note_bin"}, 32'(g[5:3]), 32'(x[5:3]));
      check({names[k], ".note_valid"}, 32'(g[2]), 32'(x[2]));
      check({names[k], ".busy"}, 32'(g[1]), 32'(x[1]));
      check({names[k], ".done"}, 32'(g[0]), 32'(x[0]));
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_step_a(input logic [3:0] s);
    int n = 0;
    while (if_a.step_idx != s && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("A.reach_step", 32'(n < 500), 32'd1);
  endtask

  initial begin
    int wait_n;
    int cnt;
    int done_before;

    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Full song, no loop: latency from start and length to the done pulse.
    pulse_start();
    wait_n = 0;
    while (!if_a.note_valid && wait_n < 10) begin
      @(negedge clk);
      wait_n++;
    end
    check("A.start_latency", 32'(wait_n), 32'd0);
    cnt = 0;
    while (!if_a.done && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check("A.done_latency", 32'(cnt), 32'd128);
    @(negedge clk);
    check("A.idle_busy", 32'(if_a.busy), 32'd0);
    check("A.idle_note", 32'(if_a.note_bin), 32'd0);
    repeat (5) @(negedge clk);

    // Looped playback never pulses done.
    loop_en = 1'b1;
    done_before = done_seen_a;
    pulse_start();
    repeat (300) @(negedge clk);
    check("A.loop_no_done", 32'(done_seen_a - done_before), 32'd0);
    loop_en = 1'b0;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    repeat (3) @(negedge clk);

    // Stop during step 5, then replay from step 0; start during step 3 is ignored.
    pulse_start();
    wait_step_a(4'd3);
    pulse_start();
    wait_step_a(4'd5);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("A.stop_valid", 32'(if_a.note_valid), 32'd0);
    check("A.stop_busy", 32'(if_a.busy), 32'd0);
    check("A.stop_step", 32'(if_a.step_idx), 32'd0);
    check("A.stop_done", 32'(if_a.done), 32'd0);
    pulse_start();
    check("A.replay_step", 32'(if_a.step_idx), 32'd0);
    check("A.replay_valid", 32'(if_a.note_valid), 32'd1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;

    // Start and stop together while idle.
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    check("A.start_stop_idle", 32'(if_a.busy), 32'd0);
    repeat (2) @(negedge clk);

    // Asynchronous reset mid-cycle during step 10.
    pulse_start();
    wait_step_a(4'd10);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("A.arst_outputs", 32'({if_a.step_idx, if_a.note_bin, if_a.note_valid, if_a.busy, if_a.done}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    check("A.arst_stays_idle", 32'(if_a.busy), 32'd0);

    // Randomised start/stop/loop/reset traffic.
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 19) == 0);
      stop = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 49) == 0) loop_en = ~loop_en;
      if ($urandom_range(0, 599) == 0) begin
        start = 1'b0;
        stop = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    start = 1'b0;
    stop = 1'b0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
